// File: rtl/bp_fe_queue_rolly.sv
// FE-side elastic buffer for the FE->BE queue. Entries stay resident until
// committed, so issued-but-uncommitted packets can be replayed (roll) and unissued ones flushed (clr).
module bp_fe_queue_rolly #(
    parameter int width_p = 1,
    parameter int els_p = 8,
    localparam int ptr_width_lp = $clog2(els_p) + 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               clr_i,
    input  logic               roll_i,
    input  logic               deq_i,
    output logic               empty_o
);

    localparam int idx_width_lp = $clog2(els_p);

    // Handshake: enqueue fires on v_i & ready_o; the consumer takes data_o by
    // raising yumi_i only while v_o is high. Outputs depend on pointers only.

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
    logic [ptr_width_lp-1:0] occupancy;
    logic                    full;
    logic                    enq_fire, yumi_fire, deq_fire;

    // Wrap bit makes full (indices equal, MSBs differ) distinct from empty.
    assign occupancy = wptr_r - cptr_r;
    assign full      = (occupancy == ptr_width_lp'(els_p));
    assign ready_o   = ~full;
    assign v_o       = (rptr_r != wptr_r);
    assign empty_o   = (wptr_r == cptr_r);
    assign data_o    = mem[rptr_r[idx_width_lp-1:0]];

    assign enq_fire  = v_i & ready_o & ~clr_i;
    assign yumi_fire = yumi_i & v_o & ~clr_i & ~roll_i;
    assign deq_fire  = deq_i & (cptr_r != rptr_r) & ~roll_i;

    always_comb begin
        cptr_n = cptr_r + ptr_width_lp'(deq_fire);
        rptr_n = rptr_r + ptr_width_lp'(yumi_fire);
        wptr_n = wptr_r + ptr_width_lp'(enq_fire);
        if (clr_i & roll_i) begin
            rptr_n = cptr_r;
            wptr_n = cptr_r;
        end else if (roll_i) begin
            rptr_n = cptr_n;
        end else if (clr_i) begin
            wptr_n = rptr_r;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[wptr_r[idx_width_lp-1:0]] <= data_i;
        end
    end

endmodule

// File: tb/tb_bp_fe_queue_rolly.sv
// Bench for bp_fe_queue_rolly: directed vector table, hand sequences for
// full/clr/roll/reset corners, and random traffic against a list-based model.
module tb_bp_fe_queue_rolly;

    localparam int W   = 8;
    localparam int ELS = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] data_i;
    logic         v_i, yumi_i, clr_i, roll_i, deq_i;
    logic         ready_o, v_o, empty_o;
    logic [W-1:0] data_o;

    always #5 clk = ~clk;

    bp_fe_queue_rolly #(.width_p(W), .els_p(ELS)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i),
        .ready_o(ready_o), .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
        .clr_i(clr_i), .roll_i(roll_i), .deq_i(deq_i), .empty_o(empty_o)
    );

    // ---------------- scoreboard / model ----------------
    // read_q: issued but not committed (oldest first); exp_q: unread entries.
    logic [W-1:0] read_q[$];
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_full();
        return (read_q.size() + exp_q.size()) == ELS;
    endfunction

    task automatic model_check();
        check("model ready_o", 32'(ready_o), 32'(!model_full()));
        check("model v_o", 32'(v_o), 32'(exp_q.size() > 0));
        check("model empty_o", 32'(empty_o), 32'(read_q.size() == 0 && exp_q.size() == 0));
        if (exp_q.size() > 0) check("model data_o", 32'(data_o), 32'(exp_q[0]));
    endtask

    task automatic model_update();
        bit enq, yum, dq;
        enq = v_i && !model_full() && !clr_i;
        yum = yumi_i && exp_q.size() > 0 && !clr_i && !roll_i;
        dq  = deq_i && read_q.size() > 0 && !roll_i;
        if (clr_i && roll_i) begin
            exp_q.delete();
            read_q.delete();
        end else if (roll_i) begin
            for (int i = read_q.size() - 1; i >= 0; i--) exp_q.push_front(read_q[i]);
            read_q.delete();
            if (enq) exp_q.push_back(data_i);
        end else if (clr_i) begin
            exp_q.delete();
            if (dq) void'(read_q.pop_front());
        end else begin
            if (dq) void'(read_q.pop_front());
            if (yum) read_q.push_back(exp_q.pop_front());
            if (enq) exp_q.push_back(data_i);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [W-1:0] d, input logic y,
                         input logic c, input logic r, input logic q);
        v_i = v; data_i = d; yumi_i = y; clr_i = c; roll_i = r; deq_i = q;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic y,
                        input logic c, input logic r, input logic q);
        drive(v, d, y, c, r, q);
        #1;
        model_check();
        advance();
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        read_q.delete();
        @(negedge clk);
        reset_n_i = 1'b1;
        check("reset v_o", 32'(v_o), 32'd0);
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset empty_o", 32'(empty_o), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic v; logic [W-1:0] d; logic y; logic c; logic r; logic q;
        logic ev; logic [W-1:0] ed; logic er; logic ee;
    } vec_t;
    vec_t tbl[24];

    initial begin
        logic [W-1:0] rd;

        // A,B,C in order, then commit; then P0..P3 with roll replay.
        tbl[0]  = '{1, 8'hA1, 0, 0, 0, 0,  0, 8'h00, 1, 1};
        tbl[1]  = '{1, 8'hB2, 1, 0, 0, 0,  1, 8'hA1, 1, 0};
        tbl[2]  = '{1, 8'hC3, 1, 0, 0, 0,  1, 8'hB2, 1, 0};
        tbl[3]  = '{0, 8'h00, 1, 0, 0, 0,  1, 8'hC3, 1, 0};
        tbl[4]  = '{0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 1, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 1, 0};
        tbl[6]  = '{0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 1, 0};
        tbl[7]  = '{0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 1, 1};
        tbl[8]  = '{1, 8'h50, 0, 0, 0, 0,  0, 8'h00, 1, 1};
        tbl[9]  = '{1, 8'h51, 0, 0, 0, 0,  1, 8'h50, 1, 0};
        tbl[10] = '{1, 8'h52, 0, 0, 0, 0,  1, 8'h50, 1, 0};
        tbl[11] = '{1, 8'h53, 0, 0, 0, 0,  1, 8'h50, 1, 0};
        tbl[12] = '{0, 8'h00, 1, 0, 0, 0,  1, 8'h50, 1, 0};
        tbl[13] = '{0, 8'h00, 1, 0, 0, 0,  1, 8'h51, 1, 0};
        tbl[14] = '{0, 8'h00, 1, 0, 0, 0,  1, 8'h52, 1, 0};
        tbl[15] = '{0, 8'h00, 0, 0, 0, 1,  1, 8'h53, 1, 0};
        tbl[16] = '{0, 8'h00, 0, 0, 1, 0,  1, 8'h53, 1, 0};
        tbl[17] = '{0, 8'h00, 1, 0, 0, 0,  1, 8'h51, 1, 0};
        tbl[18] = '{0, 8'h00, 1, 0, 0, 0,  1, 8'h52, 1, 0};
        tbl[19] = '{0, 8'h00, 1, 0, 0, 0,  1, 8'h53, 1, 0};
        tbl[20] = '{0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 1, 0};
        tbl[21] = '{0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 1, 0};
        tbl[22] = '{0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 1, 0};
        tbl[23] = '{0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 1, 1};

        do_reset();

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].c, tbl[i].r, tbl[i].q);
            #1;
            check($sformatf("tbl[%0d] v_o", i), 32'(v_o), 32'(tbl[i].ev));
            check($sformatf("tbl[%0d] ready_o", i), 32'(ready_o), 32'(tbl[i].er));
            check($sformatf("tbl[%0d] empty_o", i), 32'(empty_o), 32'(tbl[i].ee));
            if (tbl[i].ev) check($sformatf("tbl[%0d] data_o", i), 32'(data_o), 32'(tbl[i].ed));
            model_check();
            advance();
        end

        // Full: yumi does not free space, deq does.
        do_reset();
        for (int i = 0; i < ELS; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0);
        check("full ready_o", 32'(ready_o), 32'd0);
        check("full v_o", 32'(v_o), 32'd1);
        step(1, 8'hEE, 0, 0, 0, 0);
        for (int i = 0; i < ELS; i++) step(0, '0, 1, 0, 0, 0);
        check("all read ready_o", 32'(ready_o), 32'd0);
        check("all read v_o", 32'(v_o), 32'd0);
        step(0, '0, 0, 0, 0, 1);
        check("after deq ready_o", 32'(ready_o), 32'd1);
        check("after deq empty_o", 32'(empty_o), 32'd0);
        for (int i = 1; i < ELS; i++) step(0, '0, 0, 0, 0, 1);
        check("drained empty_o", 32'(empty_o), 32'd1);

        // clr drops same-cycle enqueue, keeps read entries; roll replays.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(1, 8'h64, 0, 1, 0, 0);
        check("clr v_o", 32'(v_o), 32'd0);
        check("clr empty_o", 32'(empty_o), 32'd0);
        step(0, '0, 0, 0, 1, 0);
        check("roll v_o", 32'(v_o), 32'd1);
        check("roll data_o", 32'(data_o), 32'h60);
        step(1, 8'h65, 1, 0, 0, 0);
        check("post-roll data_o", 32'(data_o), 32'h65);
        step(0, '0, 1, 0, 0, 0);
        check("post-roll drained v_o", 32'(v_o), 32'd0);

        // Illegal deq with nothing read: pointers unchanged.
        do_reset();
        step(1, 8'h77, 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 1);
        check("bad deq v_o", 32'(v_o), 32'd1);
        check("bad deq data_o", 32'(data_o), 32'h77);
        check("bad deq empty_o", 32'(empty_o), 32'd0);

        // clr & roll with 3 read-uncommitted and 2 unread flushes everything.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
        step(1, 8'h99, 1, 1, 1, 1);
        check("clr+roll empty_o", 32'(empty_o), 32'd1);
        check("clr+roll v_o", 32'(v_o), 32'd0);
        check("clr+roll ready_o", 32'(ready_o), 32'd1);

        // Random traffic across many pointer wraps.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rd = 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, rd,
                 exp_q.size() > 0 && $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 2) == 0);
        end

        // Reset mid-stream with traffic on the inputs.
        for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), i > 0, 0, 0, 0);
        reset_n_i = 1'b0;
        drive(1, 8'hDD, 1, 0, 0, 1);
        @(posedge clk);
        exp_q.delete();
        read_q.delete();
        @(negedge clk);
        reset_n_i = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        check("mid reset v_o", 32'(v_o), 32'd0);
        check("mid reset empty_o", 32'(empty_o), 32'd1);
        check("mid reset ready_o", 32'(ready_o), 32'd1);
        step(1, 8'h42, 0, 0, 0, 0);
        check("after reset data_o", 32'(data_o), 32'h42);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_fe_queue_rolly.md
# bp_fe_queue_rolly

Elastic buffer on the FE side of the FE→BE queue; it stores fetch packets and exposes the BE-facing yumi/clear/roll/dequeue controls. Three pointers: write (enqueue), read (speculative issue), commit (retired). Entries stay resident until committed, so a cache miss can replay issued-but-uncommitted packets and a flush can discard unissued packets. The FE fetch pipe is the producer; the BE scheduler is the consumer.

## Interface
- width_p, 1, packet width in bits (fe_queue_width_lp at instantiation)
- els_p, 8, entry count; power of two, ≥2
- ptr_width_lp, $clog2(els_p)+1, pointer width including wrap bit (derived)

- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- data_i  in  width_p  enqueue packet
- v_i  in  1  enqueue valid
- ready_o  out  1  enqueue ready; enqueue fires on v_i & ready_o
- data_o  out  width_p  packet at read pointer
- v_o  out  1  data_o valid (unread entry present)
- yumi_i  in  1  consumer takes data_o; legal only when v_o
- clr_i  in  1  discard all unread entries
- roll_i  in  1  rewind read pointer to commit pointer
- deq_i  in  1  retire oldest read-but-uncommitted entry
- empty_o  out  1  no entries at all (write == commit)

## Operation
- Pointers wptr, rptr, cptr, each ptr_width_lp bits; index = low bits, MSB = wrap bit; increment wraps modulo 2·els_p.
- Invariant: cptr ≤ rptr ≤ wptr (modular); occupancy = wptr − cptr ≤ els_p.
- full = (wptr − cptr == els_p); ready_o = ~full.
- v_o = (rptr != wptr); data_o = mem[rptr index], combinational read of registered storage.
- Enqueue (v_i & ready_o & ~clr_i): mem[wptr] ← data_i; wptr+1.
- yumi (yumi_i & v_o & ~clr_i & ~roll_i): rptr+1.
- deq (deq_i & (cptr != rptr) & ~roll_i): cptr+1. deq with cptr == rptr is a protocol error: ignored, pointers unchanged.
- roll_i (no clr_i): rptr ← cptr (next-cycle cptr, i.e. after any same-cycle deq, which is suppressed on roll). Enqueue in the same cycle proceeds normally.
- clr_i (no roll_i): wptr ← rptr; yumi and enqueue that cycle dropped; committed/read entries retained.
- clr_i & roll_i: rptr ← cptr, wptr ← cptr (all uncommitted state flushed); enqueue, yumi, deq dropped.
- Priority: clr/roll pointer overrides beat yumi/deq/enqueue increments; all updates occur on the same edge.
- Storage is not reset; only pointers reset.

## Timing
- Reset (reset_n_i low at edge): wptr=rptr=cptr=0. During and the cycle after: v_o=0, ready_o=1, empty_o=1; data_o don't-care while v_o=0.
- Enqueue→v_o latency: 1 cycle (no bypass; an entry written at edge N appears on data_o after edge N).
- yumi/deq/clr/roll take effect at the next edge; ready_o, v_o, empty_o are purely pointer-derived (no combinational path from any input).
- Full: ready_o=0 until a deq (or clr&roll) frees space; yumi alone does not free space.
- Wrap: pointer MSB distinguishes full (indices equal, MSBs differ) from empty (identical).
- Reset mid-operation: all pointers return to 0 at that edge regardless of other inputs; in-flight entries lost.

## Test plan
- Reset then enqueue A,B,C back-to-back → v_o rises 1 cycle after A; yumi each cycle returns A,B,C in order; empty_o=0 until 3 deqs, then 1.
- els_p=8: enqueue 8 with no deq → ready_o=0 after 8th; yumi all 8 → ready_o still 0; one deq → ready_o=1 next cycle.
- Enqueue P0..P3, yumi P0..P2, deq P0, assert roll_i → next data_o=P1, v_o=1; re-yumi yields P1,P2,P3.
- Enqueue P0..P3, yumi P0, clr_i with v_i=1 (P4) → P4 dropped, v_o=0; roll_i next → data_o=P0; new enqueue P5 follows P0.
- clr_i & roll_i with 3 read-uncommitted, 2 unread → empty_o=1, v_o=0, ready_o=1 next cycle; deq_i ignored.
- Run 3·els_p enqueue/yumi/deq cycles → order preserved across pointer wrap; deq_i with cptr==rptr leaves pointers unchanged; reset_n_i low mid-stream → v_o=0, empty_o=1 next cycle.
